fifo_param: RTL and testbench

FIFO_PARAM -- requirements
Module: fifo_param

---
 rtl/fifo_param_pkg.sv | 20 ++
 rtl/fifo_param_if.sv | 39 +++
 rtl/fifo_ns_param.sv | 47 ++++
 rtl/fifo_param.sv | 104 ++++++++++
 tb/tb_fifo_param.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/fifo_param_pkg.sv
// FIFO shared types: FSM state encoding and count width helper.
// Imported by the interface, next-state block and top.
package fifo_param_pkg;

  typedef enum logic [2:0] {
    INIT     = 3'd0,
    NO_OP    = 3'd1,
    WRITE    = 3'd2,
    WR_ERROR = 3'd3,
    READ     = 3'd4,
    RD_ERROR = 3'd5,
    WR_RD    = 3'd6
  } state_t;

  // Occupancy counter width: must hold 0..depth inclusive.
  function automatic int cw_f(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_param_if.sv
// FIFO bus: write/read requests, read data, occupancy and status flags.
// master = requester (drives wr_en/wr_data/rd_en), slave = FIFO.
interface fifo_param_if
  import fifo_param_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
);
  localparam int CW = cw_f(DEPTH);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [CW-1:0]         data_count;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  wr_ack;
  logic                  wr_err;
  logic                  rd_ack;
  logic                  rd_err;

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, data_count, full, empty,
    input  almost_full, almost_empty,
    input  wr_ack, wr_err, rd_ack, rd_err
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, data_count, full, empty,
    output almost_full, almost_empty,
    output wr_ack, wr_err, rd_ack, rd_err
  );

endinterface

// File: rtl/fifo_ns_param.sv
// FIFO next-state decode from requests, reset and occupancy.
// Ports: wr_en, rd_en, reset_n, state, data_count in; next_state out.
module fifo_ns_param
  import fifo_param_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int CW   = cw_f(DEPTH)
) (
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic          reset_n,
  input  state_t        state,
  input  logic [CW-1:0] data_count,
  output state_t        next_state
);

  logic       full;
  logic       empty;
  logic [2:0] raw;
  logic       bad;

  assign full  = (data_count == CW'(DEPTH));
  assign empty = (data_count == '0);
  assign raw   = state;
  // Encoding 7 is unused; fall back to INIT.
  assign bad   = (raw == 3'd7);

  always_comb begin
    next_state = NO_OP;
    if (!reset_n || bad) begin
      next_state = INIT;
    end else begin
      unique case ({wr_en, rd_en})
        2'b00: next_state = NO_OP;
        2'b10: next_state = full ? WR_ERROR : WRITE;
        2'b01: next_state = empty ? RD_ERROR : READ;
        default: begin
          // Both: degrade to the one legal half.
          if (empty)     next_state = WRITE;
          else if (full) next_state = READ;
          else           next_state = WR_RD;
        end
      endcase
    end
  end

endmodule

// File: rtl/fifo_param.sv
// Parameterised synchronous FIFO, FSM-sequenced, registered read data.
// Ports: clk, reset_n (sync, active-low), bus (fifo_param_if.slave).
// Macro FIFO_ALMOST_FLAGS_EN enables almost_full/almost_empty.
module fifo_param
  import fifo_param_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  fifo_param_if.slave       bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cw_f(DEPTH);

  state_t                state;
  state_t                next_state;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  do_wr;
  logic                  do_rd;

  fifo_ns_param #(
    .DEPTH(DEPTH)
  ) u_ns (
    .wr_en     (bus.wr_en),
    .rd_en     (bus.rd_en),
    .reset_n   (reset_n),
    .state     (state),
    .data_count(count),
    .next_state(next_state)
  );

  always_ff @(posedge clk) begin
    state <= next_state;
  end

  // Datapath acts on the edge that enters the state.
  assign do_wr = (next_state == WRITE) ||
                 (next_state == WR_RD);
  assign do_rd = (next_state == READ) ||
                 (next_state == WR_RD);

  // Storage is not reset; do_wr is low in reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rd_q   <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PW'(1);
      if (do_rd) begin
        rd_q   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (do_wr && !do_rd)      count <= count + CW'(1);
      else if (do_rd && !do_wr) count <= count - CW'(1);
    end
  end

  assign bus.rd_data    = rd_q;
  assign bus.data_count = count;
  assign bus.full       = (count == CW'(DEPTH));
  assign bus.empty      = (count == '0);

`ifdef FIFO_ALMOST_FLAGS_EN
  assign bus.almost_full  = (int'(count) >= AF_LEVEL);
  assign bus.almost_empty = (int'(count) <= AE_LEVEL);
`else
  assign bus.almost_full  = 1'b0;
  assign bus.almost_empty = 1'b0;
`endif

  always_comb begin
    bus.wr_ack = 1'b0;
    bus.rd_ack = 1'b0;
    bus.wr_err = 1'b0;
    bus.rd_err = 1'b0;
    unique case (1'b1)
      (state == WRITE):    bus.wr_ack = 1'b1;
      (state == READ):     bus.rd_ack = 1'b1;
      (state == WR_RD): begin
        bus.wr_ack = 1'b1;
        bus.rd_ack = 1'b1;
      end
      (state == WR_ERROR): bus.wr_err = 1'b1;
      (state == RD_ERROR): bus.rd_err = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param (DEPTH=8, AF_LEVEL=6).
// Table vectors plus queue model and read-data scoreboard.
module tb_fifo_param;
  import fifo_param_pkg::*;

  localparam int DW = 32;
  localparam int D  = 8;
  localparam int AF = 6;
  localparam int AE = 1;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  fifo_param_if #(.DATA_WIDTH(DW), .DEPTH(D)) bus ();

  fifo_param #(
    .DATA_WIDTH(DW),
    .DEPTH     (D),
    .AF_LEVEL  (AF),
    .AE_LEVEL  (AE)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] model [$];
  logic [DW-1:0] sb [$];
  logic [DW-1:0] last_rd;

  typedef struct {
    bit            wr;
    bit            rd;
    logic [DW-1:0] d;
    int            cnt;
    bit            full;
    bit            empty;
    logic [DW-1:0] rdat;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // One clock with given requests; model predicts all outputs.
  task automatic cyc(input bit wr, input bit rd,
                     input logic [DW-1:0] d);
    int n;
    bit ew, er, eew, eer;
    logic [DW-1:0] e;
    bus.wr_en   = wr;
    bus.rd_en   = rd;
    bus.wr_data = d;
    n = model.size();
    ew = 0; er = 0; eew = 0; eer = 0;
    if (wr && rd) begin
      if (n == 0)      ew = 1;
      else if (n == D) er = 1;
      else begin ew = 1; er = 1; end
    end else if (wr) begin
      if (n == D) eew = 1; else ew = 1;
    end else if (rd) begin
      if (n == 0) eer = 1; else er = 1;
    end
    if (er) sb.push_back(model.pop_front());
    if (ew) model.push_back(d);
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    chk("wr_ack", 64'(bus.wr_ack), 64'(ew));
    chk("rd_ack", 64'(bus.rd_ack), 64'(er));
    chk("wr_err", 64'(bus.wr_err), 64'(eew));
    chk("rd_err", 64'(bus.rd_err), 64'(eer));
    n = model.size();
    chk("count", 64'(bus.data_count), 64'(n));
    chk("full", 64'(bus.full), 64'(n == D));
    chk("empty", 64'(bus.empty), 64'(n == 0));
`ifdef FIFO_ALMOST_FLAGS_EN
    chk("almost_full", 64'(bus.almost_full), 64'(n >= AF));
    chk("almost_empty", 64'(bus.almost_empty), 64'(n <= AE));
`else
    chk("almost_full", 64'(bus.almost_full), 64'(0));
    chk("almost_empty", 64'(bus.almost_empty), 64'(0));
`endif
    if (er) begin
      e = sb.pop_front();
      chk("rd_data", 64'(bus.rd_data), 64'(e));
      last_rd = e;
    end else begin
      chk("rd_hold", 64'(bus.rd_data), 64'(last_rd));
    end
  endtask

  // Reset with requests asserted; they must be ignored.
  task automatic do_reset();
    reset_n     = 1'b0;
    bus.wr_en   = 1'b1;
    bus.rd_en   = 1'b1;
    bus.wr_data = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    chk("rst_count", 64'(bus.data_count), 64'(0));
    chk("rst_empty", 64'(bus.empty), 64'(1));
    chk("rst_full", 64'(bus.full), 64'(0));
    chk("rst_acks", 64'({bus.wr_ack, bus.rd_ack,
                         bus.wr_err, bus.rd_err}), 64'(0));
    chk("rst_rd_data", 64'(bus.rd_data), 64'(0));
    model.delete();
    sb.delete();
    last_rd   = '0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    reset_n   = 1'b1;
  endtask

  initial begin
    reset_n     = 1'b0;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.wr_data = '0;
    last_rd     = '0;

    // 9 writes 1..9 then 9 reads.
    for (int i = 0; i < 9; i++) begin
      tbl[i].wr    = 1;
      tbl[i].rd    = 0;
      tbl[i].d     = DW'(i + 1);
      tbl[i].cnt   = (i < 8) ? i + 1 : 8;
      tbl[i].full  = (i >= 7);
      tbl[i].empty = 0;
      tbl[i].rdat  = '0;
    end
    for (int i = 0; i < 9; i++) begin
      tbl[9+i].wr    = 0;
      tbl[9+i].rd    = 1;
      tbl[9+i].d     = '0;
      tbl[9+i].cnt   = (i < 8) ? 7 - i : 0;
      tbl[9+i].full  = 0;
      tbl[9+i].empty = (i >= 7);
      tbl[9+i].rdat  = DW'((i < 8) ? i + 1 : 8);
    end

    do_reset();
    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].wr, tbl[i].rd, tbl[i].d);
      chk("tbl_count", 64'(bus.data_count), 64'(tbl[i].cnt));
      chk("tbl_full", 64'(bus.full), 64'(tbl[i].full));
      chk("tbl_empty", 64'(bus.empty), 64'(tbl[i].empty));
      chk("tbl_rd_data", 64'(bus.rd_data), 64'(tbl[i].rdat));
    end
    chk("wr_err_9th", 64'(tbl[8].cnt), 64'(8));

    // Simultaneous at count 3: oldest out, 0xA5 later.
    do_reset();
    cyc(1, 0, 32'h11);
    cyc(1, 0, 32'h22);
    cyc(1, 0, 32'h33);
    cyc(1, 1, 32'hA5);
    chk("wrrd_old", 64'(bus.rd_data), 64'(32'h11));
    chk("wrrd_cnt", 64'(bus.data_count), 64'(3));
    cyc(0, 1, '0);
    cyc(0, 1, '0);
    cyc(0, 1, '0);
    chk("wrrd_a5", 64'(bus.rd_data), 64'(32'hA5));

    // Both requests when empty, then when full.
    do_reset();
    cyc(1, 1, 32'h5A);
    chk("both_empty_cnt", 64'(bus.data_count), 64'(1));
    for (int i = 0; i < 7; i++) cyc(1, 0, DW'(32'h60 + i));
    cyc(1, 1, 32'hFF);
    chk("both_full_cnt", 64'(bus.data_count), 64'(D - 1));
    chk("both_full_rd", 64'(bus.rd_data), 64'(32'h5A));

    // Long streaming run wraps pointers several times.
    do_reset();
    for (int i = 0; i < 24; i++)
      cyc(1, i >= 2, DW'(32'h100 + i));
    for (int i = 0; i < 40; i++)
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          $urandom);

    // Reset mid-run at count 5 drops everything.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 0, DW'(32'h200 + i));
    chk("pre_rst_cnt", 64'(bus.data_count), 64'(5));
    do_reset();
    cyc(0, 1, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
